prog_freq_divider: RTL and testbench
====================================

// Module: prog_freq_divider
// PURPOSE
//  Multi-channel programmable frequency divider for the DPWM datapath. Each channel has its own
//  period counter and generates a divided clock-enable/PWM-like output plus a period tick.
//  Two modes: TOGGLE (legacy 50% divider, output inverts every period) and DUTY (output high for
//  HIGH counts of each period). New settings are double-buffered and commit only at the period
//  boundary, so the output never glitches.
// PARAMETERS
//  NCH      4   number of independent channels (1..16)
//  W        7   counter / period / high-count width in bits
//  DEF_PER  0   period register value after reset (all channels)
//  DEF_HIGH 0   high-count register value after reset (all channels)
// PORTS
//  clkm      in   1              system clock, all logic on rising edge
//  reset     in   1              synchronous, active-high; clears all state
//  enable    in   NCH            per-channel run enable
//  mode      in   NCH            per-channel mode: 0 = DUTY, 1 = TOGGLE (sampled every cycle)
//  load      in   1              one-cycle strobe: write period_in/high_in to shadow of channel sel
//  sel       in   max(1,clog2 NCH) target channel for load
//  period_in in   W              new period value P (period length = P+1 clkm cycles)
//  high_in   in   W              new high count H (DUTY mode only)
//  fr        out  NCH            divided outputs, registered
//  tick      out  NCH            one-cycle pulse on the cycle after each period wrap
//  pend      out  NCH            1 = shadow loaded, commit not yet done
// BEHAVIOUR
//  - Reset (sync, highest priority): cnt=0, per_a=per_s=DEF_PER, high_a=high_s=DEF_HIGH,
//    pend=0, fr=0, tick=0. Reset asserted mid-period aborts it; no tick is emitted.
//  - Load: load=1 and sel<NCH -> per_s[sel]<=period_in, high_s[sel]<=high_in, pend[sel]<=1.
//    sel>=NCH: load ignored, no state changes.
//  - Disabled channel (enable=0): cnt<=0, fr<=0, tick<=0; if pend, commit happens this cycle
//    (per_a<=per_s, high_a<=high_s, pend<=0) unless a load to that channel is in the same cycle.
//  - Enabled channel, per cycle:
//     cnt==per_a (wrap): cnt<=0, tick<=1, commit shadow if pend. Else cnt<=cnt+1, tick<=0.
//     TOGGLE: fr<=~fr on wrap cycle, else hold -> output period 2*(per_a+1) cycles.
//     DUTY:   fr<=(cnt<high_a), using current cnt/high_a -> fr lags cnt by one cycle;
//             H=0 -> fr constant 0; H>=P+1 -> fr constant 1.
//  - Commit/load collision (wrap or disabled commit and load to same channel in one cycle):
//    active regs take the OLD shadow; shadow takes the new values; pend stays 1.
//  - per_a==0: counter stays 0, tick=1 every cycle, TOGGLE fr = clkm/2.
//  - Enable 0->1: first enabled cycle has cnt=0; first tick after per_a+1 enabled cycles.
//  - Mode change mid-period: takes effect on the next cycle; cnt undisturbed; fr starts from
//    its current value (TOGGLE) or is recomputed (DUTY).
//  - Unsigned arithmetic throughout; cnt never exceeds per_a (committed per_a smaller than
//    current cnt is impossible since commit only occurs at cnt==per_a or disabled).
//  - Channels fully independent; no cross-channel phase relation.
// STRUCTURE
//  - Package dpwm_div_pkg: MODE_DUTY=1'b0, MODE_TOGGLE=1'b1, default W, channel-select
//    width function.
//  - Sub-module div_channel (one channel: cnt, per_a/high_a, shadow, pend, fr, tick);
//    top instantiates NCH copies in a generate loop and decodes load/sel into per-channel
//    load strobes.
// TESTING
//  1 Reset: hold reset 3 cycles mid-run -> fr=0, tick=0, pend=0, cnt=0 on all channels.
//  2 TOGGLE, P=3, ch0 enabled -> fr period 8 cycles (4 high/4 low), tick every 4 cycles.
//  3 DUTY, P=9, H=3 -> fr high exactly 3 of every 10 cycles; H=0 -> always 0; H=12 -> always 1.
//  4 Update mid-period: P=9 running, load P=4 at cnt=2 -> pend=1, old period completes,
//    next period is 5 cycles, pend clears on the wrap cycle; no fr glitch.
//  5 Edges: P=0 TOGGLE -> fr toggles every cycle; load with sel=NCH -> no change;
//    load on wrap cycle -> old shadow committed, pend stays 1, new values on next wrap.
//  6 Disable mid-period -> next cycle cnt=0, fr=0; pending shadow committed while disabled;
//    re-enable -> first tick after P+1 cycles.

Source files
------------

// File: rtl/dpwm_div_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_div_pkg
//   Shared definitions for the DPWM programmable frequency divider.
//   - DEF_W     : default counter / period / high-count width
//   - mode_e    : per-channel output mode encoding (DUTY / TOGGLE)
//   - sel_width : width of the channel-select bus for a given channel count
// -----------------------------------------------------------------------------
package dpwm_div_pkg;

  localparam int DEF_W = 7;

  typedef enum logic {
    MODE_DUTY   = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  // A single-channel divider still needs a 1-bit select port.
  function automatic int sel_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/div_channel.sv
// -----------------------------------------------------------------------------
// div_channel
//   One divider channel: period counter, active and shadow period/high-count
//   registers, pending flag, divided output and period tick.
//   Shadow values move into the active registers only at a period wrap or while
//   the channel is disabled, so a running period is never cut short.
//
// Ports
//   clkm      in  system clock, rising edge
//   reset     in  synchronous, active-high; clears all state
//   enable    in  channel run enable
//   mode      in  0 = DUTY, 1 = TOGGLE (sampled every cycle)
//   load      in  one-cycle strobe: write period_in/high_in into the shadow
//   period_in in  new period P (period length = P+1 cycles)
//   high_in   in  new high count H (DUTY mode)
//   fr        out divided output, registered
//   tick      out one-cycle pulse on the cycle after each period wrap
//   pend      out shadow loaded, commit not yet done
// -----------------------------------------------------------------------------
module div_channel
  import dpwm_div_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int DEF_PER  = 0,
  parameter int DEF_HIGH = 0
) (
  input  logic         clkm,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic         load,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] high_in,
  output logic         fr,
  output logic         tick,
  output logic         pend
);

  localparam logic [W-1:0] RST_PER  = W'(DEF_PER);
  localparam logic [W-1:0] RST_HIGH = W'(DEF_HIGH);

  logic [W-1:0] cnt;
  logic [W-1:0] per_a;
  logic [W-1:0] high_a;
  logic [W-1:0] per_s;
  logic [W-1:0] high_s;

  logic wrap;
  logic commit;

  // A disabled channel has no period in flight, so a pending shadow can be
  // taken over immediately.
  assign wrap   = enable && (cnt == per_a);
  assign commit = pend && (!enable || wrap);

  always_ff @(posedge clkm) begin
    if (reset) begin
      cnt    <= '0;
      per_a  <= RST_PER;
      high_a <= RST_HIGH;
      per_s  <= RST_PER;
      high_s <= RST_HIGH;
      pend   <= 1'b0;
      fr     <= 1'b0;
      tick   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean the commit below reads the shadow
      // as it was before this cycle's load; a load colliding with a commit
      // therefore activates the old shadow and leaves the new one pending.
      if (load) begin
        per_s  <= period_in;
        high_s <= high_in;
      end
      if (commit) begin
        per_a  <= per_s;
        high_a <= high_s;
      end
      pend <= load || (pend && !commit);

      if (!enable) begin
        cnt  <= '0;
        fr   <= 1'b0;
        tick <= 1'b0;
      end else begin
        tick <= wrap;
        cnt  <= wrap ? '0 : cnt + W'(1);
        if (mode == MODE_TOGGLE) begin
          fr <= fr ^ wrap;
        end else begin
          // Compared against the pre-update count, so fr trails cnt by one.
          fr <= (cnt < high_a);
        end
      end
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// -----------------------------------------------------------------------------
// prog_freq_divider
//   Multi-channel programmable frequency divider for the DPWM datapath.
//   Decodes the shared load/sel write port into per-channel load strobes and
//   instantiates NCH independent div_channel instances.
//
// Ports
//   clkm      in  system clock, all logic on rising edge
//   reset     in  synchronous, active-high; clears all state
//   enable    in  [NCH] per-channel run enable
//   mode      in  [NCH] per-channel mode: 0 = DUTY, 1 = TOGGLE
//   load      in  one-cycle strobe: write period_in/high_in to shadow of sel
//   sel       in  [SW] target channel; values >= NCH are ignored
//   period_in in  [W] new period value P (period length = P+1 cycles)
//   high_in   in  [W] new high count H (DUTY mode only)
//   fr        out [NCH] divided outputs, registered
//   tick      out [NCH] one-cycle pulse on the cycle after each period wrap
//   pend      out [NCH] shadow loaded, commit not yet done
// -----------------------------------------------------------------------------
module prog_freq_divider
  import dpwm_div_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int W        = DEF_W,
  parameter  int DEF_PER  = 0,
  parameter  int DEF_HIGH = 0,
  localparam int SW       = sel_width(NCH)
) (
  input  logic           clkm,
  input  logic           reset,
  input  logic [NCH-1:0] enable,
  input  logic [NCH-1:0] mode,
  input  logic           load,
  input  logic [SW-1:0]  sel,
  input  logic [W-1:0]   period_in,
  input  logic [W-1:0]   high_in,
  output logic [NCH-1:0] fr,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0] ld_ch;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // An out-of-range sel matches no channel, so the load is dropped.
    assign ld_ch[i] = load && (sel == SW'(i));

    div_channel #(
      .W        (W),
      .DEF_PER  (DEF_PER),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .clkm      (clkm),
      .reset     (reset),
      .enable    (enable[i]),
      .mode      (mode[i]),
      .load      (ld_ch[i]),
      .period_in (period_in),
      .high_in   (high_in),
      .fr        (fr[i]),
      .tick      (tick[i]),
      .pend      (pend[i])
    );
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_freq_divider
//   Self-checking bench for prog_freq_divider (3 channels, so sel=3 is an
//   out-of-range select). A behavioural model predicts every cycle's outputs
//   into a scoreboard queue; a table of hand-derived vectors and hand-written
//   sequences check the multi-cycle corner cases against fixed expectations.
// -----------------------------------------------------------------------------
module tb_prog_freq_divider;

  localparam int NCH = 3;
  localparam int W   = 7;

  logic           clkm;
  logic           reset;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] mode;
  logic           load;
  logic [1:0]     sel;
  logic [W-1:0]   period_in;
  logic [W-1:0]   high_in;
  logic [NCH-1:0] fr;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  prog_freq_divider #(
    .NCH      (NCH),
    .W        (W),
    .DEF_PER  (0),
    .DEF_HIGH (0)
  ) dut (
    .clkm      (clkm),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .load      (load),
    .sel       (sel),
    .period_in (period_in),
    .high_in   (high_in),
    .fr        (fr),
    .tick      (tick),
    .pend      (pend)
  );

  initial clkm = 1'b0;
  always #5 clkm = ~clkm;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0]   m_cnt [NCH];
  logic [W-1:0]   m_pa  [NCH];
  logic [W-1:0]   m_ph  [NCH];
  logic [W-1:0]   m_ps  [NCH];
  logic [W-1:0]   m_hs  [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_fr;
  logic [NCH-1:0] m_tick;

  logic [3*NCH-1:0] sb_q [$];

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      logic ld, wr, cm, nfr;
      if (reset) begin
        m_cnt[i] = '0; m_pa[i] = '0; m_ph[i] = '0; m_ps[i] = '0; m_hs[i] = '0;
        m_pend[i] = 1'b0; m_fr[i] = 1'b0; m_tick[i] = 1'b0;
      end else begin
        ld  = load && (int'(sel) == i);
        wr  = enable[i] && (m_cnt[i] == m_pa[i]);
        cm  = m_pend[i] && (!enable[i] || wr);
        if (!enable[i])  nfr = 1'b0;
        else if (mode[i]) nfr = m_fr[i] ^ wr;
        else              nfr = (m_cnt[i] < m_ph[i]);
        m_fr[i]   = nfr;
        m_tick[i] = wr;
        m_cnt[i]  = (!enable[i] || wr) ? '0 : m_cnt[i] + 7'd1;
        if (cm) begin m_pa[i] = m_ps[i]; m_ph[i] = m_hs[i]; end
        if (ld) begin m_ps[i] = period_in; m_hs[i] = high_in; end
        m_pend[i] = ld || (m_pend[i] && !cm);
      end
    end
  endtask

  // One clock: predict, advance, compare the prediction, drop the load strobe.
  task automatic cycle();
    logic [3*NCH-1:0] e;
    model_step();
    sb_q.push_back({m_fr, m_tick, m_pend});
    @(posedge clkm);
    #1;
    e = sb_q.pop_front();
    check("sb", {fr, tick, pend}, e);
    load = 1'b0;
  endtask

  task automatic do_load(input int ch, input int p, input int h);
    load      = 1'b1;
    sel       = 2'(ch);
    period_in = 7'(p);
    high_in   = 7'(h);
    cycle();
  endtask

  // Cycles until tick[ch] is seen (inclusive); returns max if it never shows.
  task automatic wait_tick(input int ch, input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick[ch] && n < max);
  endtask

  task automatic count_high(input int ch, input int ncyc, output int hi, output int tk);
    hi = 0;
    tk = 0;
    for (int k = 0; k < ncyc; k++) begin
      cycle();
      hi += int'(fr[ch]);
      tk += int'(tick[ch]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for channel 0 (TOGGLE)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         en0;
    logic         ld;
    logic [1:0]   sel;
    logic [W-1:0] per;
    logic [W-1:0] hi;
    logic         fr0;
    logic         tick0;
    logic         pend0;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, tk;

    reset = 1'b1; enable = '0; mode = 3'b101; load = 1'b0;
    sel = '0; period_in = '0; high_in = '0;
    cycle();
    cycle();
    check("reset_state", {fr, tick, pend}, '0);
    reset = 1'b0;

    //           en ld sel per hi   fr tk pd
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 7'd3, 7'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'd3, 7'd1, 7'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0};

    for (int r = 0; r < 16; r++) begin
      enable[0] = tbl[r].en0;
      load      = tbl[r].ld;
      sel       = tbl[r].sel;
      period_in = tbl[r].per;
      high_in   = tbl[r].hi;
      cycle();
      check($sformatf("tbl%0d", r), {fr[0], tick[0], pend[0]},
            {tbl[r].fr0, tbl[r].tick0, tbl[r].pend0});
      if (r == 10) check("sel_out_of_range_pend", pend, '0);
    end

    // P=0 TOGGLE on ch0: commit at the next wrap, then toggle every cycle.
    do_load(0, 0, 0);
    check("p0_pend", pend[0], 1'b1);
    wait_tick(0, 20, n);
    check("p0_commit_wait", n, 1);
    check("p0_commit_fr", {fr[0], pend[0]}, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check($sformatf("p0_toggle%0d", k), {fr[0], tick[0]}, {1'(k % 2), 1'b1});
    end

    // Load on a wrap cycle while a load is already pending on ch0.
    do_load(0, 5, 0);
    check("coll_first", {tick[0], pend[0]}, 2'b11);
    do_load(0, 2, 0);
    check("coll_second", {tick[0], pend[0]}, 2'b11);
    wait_tick(0, 20, n);
    check("coll_old_period", n, 6);
    check("coll_pend_clear", pend[0], 1'b0);
    wait_tick(0, 20, n);
    check("coll_new_period", n, 3);

    // DUTY on ch1: P=9, H=3.
    do_load(1, 9, 3);
    cycle();
    check("ch1_disabled_commit", pend[1], 1'b0);
    enable[1] = 1'b1;
    wait_tick(1, 40, n);
    check("duty_first_tick", n, 10);
    count_high(1, 10, hi, tk);
    check("duty_h3_high", hi, 3);
    check("duty_h3_ticks", tk, 1);

    // Mid-period update at cnt=2: old period completes, new one is 5 cycles.
    cycle();
    cycle();
    do_load(1, 4, 2);
    check("upd_pend", pend[1], 1'b1);
    wait_tick(1, 40, n);
    check("upd_old_rest", n, 7);
    check("upd_pend_clear", pend[1], 1'b0);
    count_high(1, 5, hi, tk);
    check("upd_new_high", hi, 2);
    check("upd_new_tick", {tk[3:0], tick[1]}, {4'd1, 1'b1});

    // H=0 -> constant low, H=12 > P -> constant high.
    do_load(1, 9, 0);
    wait_tick(1, 40, n);
    check("h0_wait", n, 4);
    count_high(1, 10, hi, tk);
    check("h0_high", hi, 0);
    do_load(1, 9, 12);
    wait_tick(1, 40, n);
    check("h12_wait", n, 9);
    count_high(1, 10, hi, tk);
    check("h12_high", hi, 10);

    // Disable mid-period on ch2 with a pending shadow, then re-enable.
    do_load(2, 2, 0);
    cycle();
    enable[2] = 1'b1;
    wait_tick(2, 20, n);
    check("ch2_first_tick", n, 3);
    cycle();
    do_load(2, 4, 0);
    check("dis_pend_before", {fr[2], pend[2]}, 2'b11);
    enable[2] = 1'b0;
    cycle();
    check("dis_outputs", {fr[2], tick[2], pend[2]}, 3'b000);
    cycle();
    enable[2] = 1'b1;
    wait_tick(2, 20, n);
    check("reenable_first_tick", n, 5);
    check("reenable_fr", fr[2], 1'b1);

    // Reset held for three cycles mid-run with a pending load.
    enable = 3'b111;
    do_load(0, 7, 1);
    check("pre_reset_pend", pend[0], 1'b1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("reset_hold%0d", k), {fr, tick, pend}, '0);
    end
    reset = 1'b0;
    cycle();
    check("post_reset", {fr, tick, pend}, {3'b101, 3'b111, 3'b000});

    // Random traffic checked against the model only.
    for (int k = 0; k < 400; k++) begin
      enable    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : enable;
      mode      = ($urandom_range(0, 19) == 0) ? 3'($urandom) : mode;
      load      = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom_range(0, 3));
      period_in = 7'($urandom_range(0, 12));
      high_in   = 7'($urandom_range(0, 14));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
